// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants shared by the ALU and the control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] ALU_AND  = 4'b0000;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OR   = 4'b0001;
    localparam logic [OPCODE_WIDTH-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OPCODE_WIDTH-1:0] ALU_XOR  = 4'b0011;
    localparam logic [OPCODE_WIDTH-1:0] ALU_SLL  = 4'b0100;
    localparam logic [OPCODE_WIDTH-1:0] ALU_SRL  = 4'b0101;
    localparam logic [OPCODE_WIDTH-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OPCODE_WIDTH-1:0] ALU_SLT  = 4'b0111;
    localparam logic [OPCODE_WIDTH-1:0] ALU_SRA  = 4'b1000;
    localparam logic [OPCODE_WIDTH-1:0] ALU_SLTU = 4'b1001;
    localparam logic [OPCODE_WIDTH-1:0] ALU_NOR  = 4'b1100;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module      : alu_core
// Description : Combinational RV32 integer ALU datapath, one shared adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [OPCODE_WIDTH-1:0] operation,
    input  logic [DATA_WIDTH-1:0]   X,
    input  logic [DATA_WIDTH-1:0]   Y,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic                   subtract;
    logic [DATA_WIDTH-1:0]  adder_b;
    logic [DATA_WIDTH-1:0]  adder_sum;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   lt_signed;
    logic                   lt_unsigned;
    logic [DATA_WIDTH-1:0]  sra_result;

    // Subtraction reuses the adder as X + ~Y + 1.
    assign subtract  = (operation == ALU_SUB);
    assign adder_b   = subtract ? ~Y : Y;
    assign adder_sum = X + adder_b + {{(DATA_WIDTH-1){1'b0}}, subtract};

    assign shamt       = Y[SHAMT_WIDTH-1:0];
    assign lt_signed   = ($signed(X) < $signed(Y));
    assign lt_unsigned = (X < Y);
    assign sra_result  = $signed(X) >>> shamt;

    always_comb begin
        result = '0;
        case (operation)
            ALU_AND:  result = X & Y;
            ALU_OR:   result = X | Y;
            ALU_ADD:  result = adder_sum;
            ALU_XOR:  result = X ^ Y;
            ALU_SLL:  result = X << shamt;
            ALU_SRL:  result = X >> shamt;
            ALU_SUB:  result = adder_sum;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
            ALU_SRA:  result = sra_result;
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
            ALU_NOR:  result = ~(X | Y);
            default:  result = '0;
        endcase
    end

endmodule : alu_core

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Registered RV32 ALU: result and zero flag, one-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] operation,
    input  logic [DATA_WIDTH-1:0]   ALU_in_X,
    input  logic [DATA_WIDTH-1:0]   ALU_in_Y,
    output logic [DATA_WIDTH-1:0]   ALU_out_S,
    output logic                    ZR
);

    logic [DATA_WIDTH-1:0] result;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .operation (operation),
        .X         (ALU_in_X),
        .Y         (ALU_in_Y),
        .result    (result)
    );

    // Flag is derived from the same comb result so it can never lag the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_out_S <= '0;
            ZR        <= 1'b1;
        end else begin
            ALU_out_S <= result;
            ZR        <= (result == '0);
        end
    end

endmodule : alu

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  operation;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] alu_out_s;
    logic        zr;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    alu #(
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operation (operation),
        .ALU_in_X  (x),
        .ALU_in_Y  (y),
        .ALU_out_S (alu_out_s),
        .ZR        (zr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        int          sh;
        sh = int'(b[4:0]);
        r  = 32'd0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a ^ b;
            4'd4:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd6:  r = a - b;
            4'd7:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd8: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
            end
            4'd9:  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Every capture edge outside reset is compared against the model.
    always begin
        logic [31:0] e;
        @(posedge clk);
        if (checking && rst_n) begin
            e = model(operation, x, y);
            #1;
            check("model_S", alu_out_s, e);
            check("model_ZR", {31'd0, zr}, {31'd0, (e == 32'd0)});
        end
    end

    task automatic apply(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] lit);
        @(negedge clk);
        operation = op;
        x         = a;
        y         = b;
        check({name, "_model"}, model(op, a, b), lit);
        @(posedge clk);
        #1;
        check(name, alu_out_s, lit);
        check({name, "_ZR"}, {31'd0, zr}, {31'd0, (lit == 32'd0)});
    endtask

    initial begin
        rst_n     = 1'b1;
        operation = 4'd2;
        x         = $urandom;
        y         = $urandom;
        #2 rst_n  = 1'b0;
        #1;
        check("reset_async_S", alu_out_s, 32'd0);
        check("reset_async_ZR", {31'd0, zr}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            operation = 4'($urandom_range(0, 15));
            x         = $urandom | 32'h1;
            y         = $urandom;
            @(posedge clk);
            #1;
            check("reset_hold_S", alu_out_s, 32'd0);
            check("reset_hold_ZR", {31'd0, zr}, 32'd1);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        checking = 1'b1;

        apply("add",   4'b0010, 32'd2565, 32'd1560, 32'd4125);
        apply("and",   4'b0000, 32'd2565, 32'd1560, 32'h0000_0200);
        apply("or",    4'b0001, 32'd2565, 32'd1560, 32'h0000_0E1D);
        apply("nor",   4'b1100, 32'd2565, 32'd1560, 32'hFFFF_F1E2);
        apply("xor",   4'b0011, 32'd2565, 32'd1560, 32'h0000_0C1D);
        apply("sub1",  4'b0110, 32'd2565, 32'd1560, 32'd1005);
        apply("sub2",  4'b0110, 32'd2565, -32'sd3560, 32'd6125);
        apply("sub3",  4'b0110, 32'd2565, 32'd3560, 32'hFFFF_FC1D);
        apply("sub0",  4'b0110, 32'd7, 32'd7, 32'd0);
        apply("slt1",  4'b0111, 32'd2565, 32'd1560, 32'd0);
        apply("slt2",  4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("sltu1", 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("sltu2", 4'b1001, 32'd1, 32'hFFFF_FFFF, 32'd1);
        apply("slt3",  4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
        apply("slt_eq", 4'b0111, 32'h8000_0000, 32'h8000_0000, 32'd0);
        apply("sll",   4'b0100, 32'h8000_0001, 32'd4, 32'h0000_0010);
        apply("srl",   4'b0101, 32'h8000_0001, 32'd4, 32'h0800_0000);
        apply("sra",   4'b1000, 32'h8000_0001, 32'd4, 32'hF800_0000);
        apply("sra_hi", 4'b1000, 32'h8000_0001, 32'h0000_0024, 32'hF800_0000);
        apply("sll_hi", 4'b0100, 32'h8000_0001, 32'hFFFF_FFE4, 32'h0000_0010);
        apply("sll0",  4'b0100, 32'h8000_0001, 32'd0, 32'h8000_0001);
        apply("srl0",  4'b0101, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001);
        apply("sra0",  4'b1000, 32'h8000_0001, 32'd0, 32'h8000_0001);
        apply("op15",  4'b1111, 32'd2565, 32'd1560, 32'd0);
        apply("op10",  4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        apply("add_pre_rst", 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1);

        // Asynchronous clear between edges, held across one edge.
        #2;
        checking = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_S", alu_out_s, 32'd0);
        check("midrst_ZR", {31'd0, zr}, 32'd1);
        @(posedge clk);
        #1;
        check("midrst_hold_S", alu_out_s, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        checking = 1'b1;

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            operation = 4'($urandom_range(0, 15));
            x         = pick();
            y         = pick();
        end
        @(posedge clk);
        #2;
        checking = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu

`default_nettype wire
